sha1_mem_ctrl: RTL and testbench
================================

Name: sha1_mem_ctrl

Overview:
Bus-master front end that drives the sha1_dfa hash core from the CPU side. It accepts a command holding source and destination addresses, fetches the 32-bit message word from memory, and launches the core. It then waits for the core's ready, captures the 160-bit digest, and writes it back to memory as five 32-bit words. It sits between the tinyriscv system bus and sha1_dfa.

Parameters:
RESULT_WORDS, 5, number of 32-bit digest words written back (160/32).
TIMEOUT_CYCLES, 4096, watchdog limit in clocks for core_ready_i; used only with SHA1_CTRL_TIMEOUT_EN.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid_i  input  1  CPU command valid
cmd_ready_o  output  1  controller can accept a command (high only in IDLE)
cmd_src_i  input  32  byte address of message word
cmd_dst_i  input  32  byte address of digest buffer
busy_o  output  1  command in progress (state != IDLE)
done_o  output  1  one-cycle pulse when the digest write-back completes
err_o  output  1  sticky timeout flag, cleared on next accepted command
mem_req_o  output  1  memory request
mem_we_o  output  1  1=write, 0=read
mem_addr_o  output  32  word-aligned memory address
mem_wdata_o  output  32  write data
mem_rdata_i  input  32  read data, valid with mem_ack_i
mem_ack_i  input  1  transfer complete
core_para_o  output  32  message word to core (para_i)
core_start_o  output  1  core start pulse (start_i)
core_addr_o  output  32  source address forwarded to core (sha1_addr_i)
core_result_i  input  160  digest from core (result_o)
core_ready_i  input  1  core digest valid (ready_o)
core_busy_i  input  1  core busy (busy_o)

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0 except cmd_ready_o=1. Internal src, dst, para, and digest registers are cleared. An in-flight memory transfer is abandoned and mem_req_o drops immediately.
- Addresses: bits [1:0] of cmd_src_i and cmd_dst_i are forced to 0 on capture. dst+4k is computed modulo 2^32, so it wraps with no error.
- IDLE: when cmd_valid_i && cmd_ready_o, capture src/dst, clear err_o, go to RD.
- RD: mem_req_o=1, mem_we_o=0, mem_addr_o=src, all held stable until mem_ack_i. On the ack cycle, capture mem_rdata_i into para, drop mem_req_o the next cycle, go to START.
- START: if core_busy_i=1, stay in START. Otherwise assert core_start_o=1 for exactly one cycle, with core_para_o=para and core_addr_o=src, then go to WAIT. core_para_o and core_addr_o stay held until IDLE is re-entered; they are 0 in IDLE.
- WAIT: on the first cycle with core_ready_i=1, latch core_result_i, set word index k=0, go to WR. A core_ready_i that is already high on WAIT entry counts; the minimum WAIT dwell is 1 cycle.
- WR: mem_req_o=1, mem_we_o=1, mem_addr_o=dst+4k, mem_wdata_o=digest[159-32k -: 32]. H0 (bits 159:128) goes to the lowest address. On ack, k increments and mem_req_o deasserts for one cycle before the next word. After ack of k=RESULT_WORDS-1, go to DONE.
- DONE: done_o=1 for one cycle, then IDLE. cmd_ready_o=0 here, so a cmd_valid_i in DONE waits until the following cycle.
- Each memory transfer takes at least 2 cycles (req cycle plus ack cycle). mem_ack_i while mem_req_o=0 is ignored.
- Minimum command latency with zero-wait memory and immediate core ready, accept to done_o: 2 (RD) + 1 (START) + 1 (WAIT) + 5×2 (WR) + 1 (DONE) = 15 cycles.
- Reset mid-operation returns to IDLE with no done_o. The core is not reset by this block.

Optional Feature:
SHA1_CTRL_TIMEOUT_EN
- Defined: a counter runs in WAIT. If core_ready_i has not been seen within TIMEOUT_CYCLES cycles, the block sets err_o=1 (sticky), skips WR, pulses done_o, and returns to IDLE with nothing written.
- Undefined: no counter. WAIT lasts indefinitely and err_o is tied 0.

Test Plan:
- Basic hash: cmd_src=0x10001000 holding 0x31323334 ("1234"), cmd_dst=0x20000000, core model returns 0x7110eda4_d09e062a_a5e4a390_b0a572ac_0d2c0220 after 20 cycles -> one read at 0x10001000; one core_start_o pulse with para=0x31323334 and addr=0x10001000; writes in order 0x20000000=7110eda4, +4=d09e062a, +8=a5e4a390, +C=b0a572ac, +10=0d2c0220; single done_o.
- Latency: zero-wait ack and core_ready_i high on WAIT entry -> done_o exactly 15 cycles after the command handshake; cmd_ready_o=0 throughout, 1 the cycle after done_o.
- Backpressure and busy: mem_ack_i delayed 3 cycles per transfer and core_busy_i=1 for 5 cycles at START -> addr/wdata stable while req is high; start delayed until busy drops; written data unchanged.
- Alignment and wrap: cmd_src=0x10001003, cmd_dst=0xFFFFFFF8 -> read at 0x10001000; writes at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004, 0x00000008.
- Reset mid-op: assert rst during the third WR ack wait -> all outputs 0 and cmd_ready_o=1 immediately, no done_o; a new command then completes normally.
- Timeout (SHA1_CTRL_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): core never ready -> err_o=1 and done_o pulse 16 cycles after WAIT entry, no write requests; the next command clears err_o.

Source files
------------

// File: rtl/sha1_mem_ctrl.sv
// sha1_mem_ctrl: bus-master front end for the sha1_dfa hash core.
// Accepts a command (source/destination byte addresses), reads the 32-bit
// message word, launches the core, waits for its digest and writes the
// 160-bit result back as five 32-bit words, H0 at the lowest address.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_*               CPU command handshake (valid/ready, src, dst)
//   busy_o/done_o/err_o status: in progress, completion pulse, sticky timeout
//   mem_*               single-outstanding memory master (req/ack)
//   core_*              sha1_dfa interface (para, start, addr, result, ready, busy)
//
// Optional feature macro: SHA1_CTRL_TIMEOUT_EN
//   defined   -> watchdog of TIMEOUT_CYCLES clocks on core_ready_i; on expiry
//                err_o is set, write-back is skipped and done_o still pulses.
//   undefined -> WAIT lasts indefinitely, err_o stays 0.
//
// Memory timing: mem_req_o is registered one cycle behind the state, so every
// transfer spends one cycle with req low followed by the req/ack cycle(s).
// With a zero-wait memory (ack in the first req cycle) this yields 2 cycles
// per transfer and a 15-cycle accept-to-done latency.

module sha1_mem_ctrl #(
  parameter int unsigned RESULT_WORDS = 5
`ifdef SHA1_CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [31:0]  cmd_src_i,
  input  logic [31:0]  cmd_dst_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [31:0]  mem_wdata_o,
  input  logic [31:0]  mem_rdata_i,
  input  logic         mem_ack_i,
  output logic [31:0]  core_para_o,
  output logic         core_start_o,
  output logic [31:0]  core_addr_o,
  input  logic [159:0] core_result_i,
  input  logic         core_ready_i,
  input  logic         core_busy_i
);

  localparam int unsigned DIGEST_W = 160;
  localparam int unsigned K_W      = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [31:0]          r_para;
  logic [DIGEST_W-1:0]  r_digest;
  logic [K_W-1:0]       r_k;
  logic                 r_err;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_mem_wdata;

  logic                 w_cmd_fire;
  logic                 w_xfer_done;
  logic                 w_last_word;
  logic                 w_timeout;
  logic                 w_req_next;
  logic [31:0]          w_wr_addr;
  logic [31:0]          w_wr_data;

  assign w_cmd_fire  = cmd_valid_i && (r_state == S_IDLE);
  // An ack only counts while a request is actually on the bus.
  assign w_xfer_done = r_mem_req && mem_ack_i;
  assign w_last_word = (r_k == K_W'(RESULT_WORDS - 1));

  // Word k goes to dst+4k (wraps modulo 2^32); H0 is the top digest word.
  assign w_wr_addr = r_dst + 32'({r_k, 2'b00});
  assign w_wr_data = 32'(r_digest >> (32 * (RESULT_WORDS - 1 - 32'(r_k))));

`ifdef SHA1_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] r_tmo_cnt;

  // Watchdog: counts WAIT cycles, expires on the last allowed one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !core_ready_i &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_fire)   w_next = S_RD;
      S_RD:    if (w_xfer_done)  w_next = S_START;
      S_START: if (!core_busy_i) w_next = S_WAIT;
      S_WAIT: begin
        if (core_ready_i)   w_next = S_WR;
        else if (w_timeout) w_next = S_DONE;
      end
      S_WR:    if (w_xfer_done && w_last_word) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    cmd_ready_o  = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    core_start_o = 1'b0;
    core_para_o  = 32'd0;
    core_addr_o  = 32'd0;
    case (r_state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_START: begin
        core_start_o = !core_busy_i;
        core_para_o  = r_para;
        core_addr_o  = r_src;
      end
      S_WAIT, S_WR: begin
        core_para_o = r_para;
        core_addr_o = r_src;
      end
      S_DONE: begin
        done_o      = 1'b1;
        core_para_o = r_para;
        core_addr_o = r_src;
      end
      default: ;
    endcase
  end

  // Request for the next cycle: drops on the ack cycle, giving the one-cycle gap.
  assign w_req_next = ((r_state == S_RD) || (r_state == S_WR)) && !w_xfer_done;

  // Command capture, read data, digest, word index and bus registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src       <= 32'd0;
      r_dst       <= 32'd0;
      r_para      <= 32'd0;
      r_digest    <= '0;
      r_k         <= '0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      if (w_cmd_fire) begin
        r_src <= cmd_src_i & 32'hFFFF_FFFC;
        r_dst <= cmd_dst_i & 32'hFFFF_FFFC;
        r_err <= 1'b0;
      end
      if ((r_state == S_RD) && w_xfer_done) begin
        r_para <= mem_rdata_i;
      end
      if ((r_state == S_WAIT) && core_ready_i) begin
        r_digest <= core_result_i;
        r_k      <= '0;
      end
      if ((r_state == S_WR) && w_xfer_done) begin
        r_k <= r_k + K_W'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end

      r_mem_req <= w_req_next;
      r_mem_we  <= w_req_next && (r_state == S_WR);
      if (w_req_next) begin
        r_mem_addr  <= (r_state == S_WR) ? w_wr_addr : r_src;
        r_mem_wdata <= (r_state == S_WR) ? w_wr_data : 32'd0;
      end else begin
        r_mem_addr  <= 32'd0;
        r_mem_wdata <= 32'd0;
      end
    end
  end

  assign err_o       = r_err;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_sha1_mem_ctrl.sv
// Directed self-checking bench for sha1_mem_ctrl with a req/ack memory model
// (programmable wait states) and a sha1 core model (programmable ready).

module tb_sha1_mem_ctrl;

  localparam logic [159:0] DIGEST = 160'h7110eda4_d09e062a_a5e4a390_b0a572ac_0d2c0220;
  localparam logic [31:0]  MSG_ADDR = 32'h1000_1000;
  localparam logic [31:0]  MSG_WORD = 32'h3132_3334;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [31:0]  cmd_src_i;
  logic [31:0]  cmd_dst_i;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [31:0]  mem_wdata_o;
  logic [31:0]  mem_rdata_i;
  logic         mem_ack_i;
  logic [31:0]  core_para_o;
  logic         core_start_o;
  logic [31:0]  core_addr_o;
  logic [159:0] core_result_i;
  logic         core_ready_i;
  logic         core_busy_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sha1_mem_ctrl #(
    .RESULT_WORDS(5)
`ifdef SHA1_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_src_i(cmd_src_i), .cmd_dst_i(cmd_dst_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .core_para_o(core_para_o), .core_start_o(core_start_o), .core_addr_o(core_addr_o),
    .core_result_i(core_result_i), .core_ready_i(core_ready_i), .core_busy_i(core_busy_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: ack after mem_lat extra req cycles; data valid only with ack.
  int mem_lat = 0;
  int mem_cnt = 0;
  assign mem_ack_i   = mem_req_o && (mem_cnt == mem_lat);
  assign mem_rdata_i = !mem_ack_i ? 32'hDEAD_BEEF :
                       (mem_addr_o == MSG_ADDR) ? MSG_WORD : (32'hBAD0_0000 ^ mem_addr_o);
  always @(posedge clk) begin
    if (mem_req_o && !mem_ack_i) mem_cnt <= mem_cnt + 1;
    else                         mem_cnt <= 0;
  end

  // Core model: 0 = one-cycle ready core_lat cycles after start, 1 = ready always, 2 = never.
  int   core_mode = 0;
  int   core_lat  = 20;
  int   core_cnt  = 0;
  logic core_act  = 1'b0;
  always @(posedge clk) begin
    if (core_start_o) begin
      core_act <= 1'b1;
      core_cnt <= core_lat;
    end else if (core_act) begin
      if (core_cnt == 0) core_act <= 1'b0;
      else               core_cnt <= core_cnt - 1;
    end
  end
  assign core_ready_i  = (core_mode == 1) || ((core_mode == 0) && core_act && (core_cnt == 0));
  assign core_result_i = core_ready_i ? DIGEST : ~DIGEST;

  // Transaction logs and bus-stability monitor.
  logic [31:0] rd_addr_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          n_start = 0;
  int          n_done  = 0;
  int          stab_err = 0;
  logic [31:0] st_para = 32'd0;
  logic [31:0] st_addr = 32'd0;
  logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;

  always @(posedge clk) begin
    if (mem_req_o && mem_ack_i) begin
      if (mem_we_o) begin
        wr_addr_q.push_back(mem_addr_o);
        wr_data_q.push_back(mem_wdata_o);
      end else begin
        rd_addr_q.push_back(mem_addr_o);
      end
    end
    if (core_start_o) begin
      n_start++;
      st_para = core_para_o;
      st_addr = core_addr_o;
    end
    if (done_o) n_done++;
    if (!rst && p_req && !p_ack &&
        (!mem_req_o || mem_addr_o !== p_addr || mem_wdata_o !== p_wdata || mem_we_o !== p_we))
      stab_err++;
    p_req   = mem_req_o;
    p_ack   = mem_ack_i;
    p_we    = mem_we_o;
    p_addr  = mem_addr_o;
    p_wdata = mem_wdata_o;
  end

  task automatic clear_logs();
    rd_addr_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    n_start  = 0;
    n_done   = 0;
    stab_err = 0;
  endtask

  // Presents a command at a negedge; returns #1 after the handshake edge.
  task automatic send_cmd(input logic [31:0] src, input logic [31:0] dst);
    int t;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_src_i   = src;
    cmd_dst_i   = dst;
    t = 0;
    while (!cmd_ready_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("cmd_accept", 32'(cmd_ready_o), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int t;
    t = 0;
    while (!done_o && t < max) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, 32'(done_o), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] dst);
    logic [159:0] d;
    d = DIGEST;
    check({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_addr_q.size()) begin
        check($sformatf("%s_wa%0d", tag, i), wr_addr_q[i], dst + 32'(4 * i));
        check($sformatf("%s_wd%0d", tag, i), wr_data_q[i], d[159 - 32 * i -: 32]);
      end
    end
  endtask

  initial begin
    int t;
    rst         = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_src_i   = 32'd0;
    cmd_dst_i   = 32'd0;
    core_busy_i = 1'b0;
    clear_logs();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_busy",      32'(busy_o),      32'd0);
    check("rst_done",      32'(done_o),      32'd0);
    check("rst_err",       32'(err_o),       32'd0);
    check("rst_mem_req",   32'(mem_req_o),   32'd0);
    check("rst_mem_addr",  mem_addr_o,       32'd0);
    check("rst_core_start", 32'(core_start_o), 32'd0);
    check("rst_core_para", core_para_o,      32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic hash, core ready 20 cycles after start
    mem_lat = 0; core_mode = 0; core_lat = 20;
    clear_logs();
    send_cmd(MSG_ADDR, 32'h2000_0000);
    wait_done("basic", 200);
    check("basic_nrd",    32'(rd_addr_q.size()), 32'd1);
    if (rd_addr_q.size() > 0) check("basic_rd_addr", rd_addr_q[0], MSG_ADDR);
    check("basic_nstart", 32'(n_start), 32'd1);
    check("basic_para",   st_para, MSG_WORD);
    check("basic_caddr",  st_addr, MSG_ADDR);
    check_writes("basic", 32'h2000_0000);
    check("basic_ndone",  32'(n_done), 32'd1);
    check("basic_err",    32'(err_o), 32'd0);
    check("basic_idle_para", core_para_o, 32'd0);
    check("basic_stab",   32'(stab_err), 32'd0);

    // Minimum latency: zero-wait memory, core ready already high
    core_mode = 1;
    clear_logs();
    send_cmd(MSG_ADDR, 32'h3000_0000);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check($sformatf("lat_ready_c%0d", i), 32'(cmd_ready_o), 32'd0);
      check($sformatf("lat_done_c%0d", i),  32'(done_o), 32'(i == 15));
    end
    @(negedge clk);
    check("lat_ready_after", 32'(cmd_ready_o), 32'd1);
    check("lat_done_after",  32'(done_o), 32'd0);
    check_writes("lat", 32'h3000_0000);
    core_mode = 0;

    // Backpressure: 3 wait states per transfer, core busy 5 cycles at START
    mem_lat = 3; core_lat = 5; core_busy_i = 1'b1;
    clear_logs();
    send_cmd(MSG_ADDR, 32'h4000_0000);
    t = 0;
    while (rd_addr_q.size() == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_read_seen", 32'(rd_addr_q.size()), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_nostart%0d", i), 32'(core_start_o), 32'd0);
    end
    check("bp_nstart_busy", 32'(n_start), 32'd0);
    core_busy_i = 1'b0;
    wait_done("bp", 300);
    check("bp_nstart", 32'(n_start), 32'd1);
    check("bp_para",   st_para, MSG_WORD);
    check_writes("bp", 32'h4000_0000);
    check("bp_stab",   32'(stab_err), 32'd0);
    check("bp_ndone",  32'(n_done), 32'd1);

    // Alignment and address wrap
    mem_lat = 0; core_lat = 3;
    clear_logs();
    send_cmd(32'h1000_1003, 32'hFFFF_FFFB);
    wait_done("wrap", 200);
    if (rd_addr_q.size() > 0) check("wrap_rd_addr", rd_addr_q[0], MSG_ADDR);
    check("wrap_caddr", st_addr, MSG_ADDR);
    check("wrap_para",  st_para, MSG_WORD);
    check_writes("wrap", 32'hFFFF_FFF8);

    // Reset during the third write's ack wait
    mem_lat = 3;
    clear_logs();
    send_cmd(MSG_ADDR, 32'h5000_0000);
    t = 0;
    while (wr_addr_q.size() < 2 && t < 300) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (!(mem_req_o && mem_we_o) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mid_req_before", 32'(mem_req_o), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_mem_req",    32'(mem_req_o),   32'd0);
    check("mid_mem_we",     32'(mem_we_o),    32'd0);
    check("mid_mem_addr",   mem_addr_o,       32'd0);
    check("mid_mem_wdata",  mem_wdata_o,      32'd0);
    check("mid_cmd_ready",  32'(cmd_ready_o), 32'd1);
    check("mid_busy",       32'(busy_o),      32'd0);
    check("mid_done",       32'(done_o),      32'd0);
    check("mid_core_addr",  core_addr_o,      32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_ndone", 32'(n_done), 32'd0);
    check("mid_nwr",   32'(wr_addr_q.size()), 32'd2);
    mem_lat = 0;
    clear_logs();
    send_cmd(MSG_ADDR, 32'h6000_0000);
    wait_done("post", 200);
    check_writes("post", 32'h6000_0000);
    check("post_ndone", 32'(n_done), 32'd1);

`ifdef SHA1_CTRL_TIMEOUT_EN
    // Watchdog: core never ready
    core_mode = 2;
    clear_logs();
    send_cmd(MSG_ADDR, 32'h7000_0000);
    t = 0;
    while (!core_start_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("tmo_start", 32'(core_start_o), 32'd1);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      check($sformatf("tmo_done_c%0d", i), 32'(done_o), 32'(i == 17));
    end
    check("tmo_err", 32'(err_o), 32'd1);
    @(negedge clk);
    check("tmo_err_sticky", 32'(err_o), 32'd1);
    check("tmo_nwr",   32'(wr_addr_q.size()), 32'd0);
    check("tmo_ndone", 32'(n_done), 32'd1);
    core_mode = 0;
    clear_logs();
    send_cmd(MSG_ADDR, 32'h7100_0000);
    check("tmo_err_clear", 32'(err_o), 32'd0);
    wait_done("tmo_next", 200);
    check_writes("tmo_next", 32'h7100_0000);
`else
    // No watchdog: WAIT persists with err_o low
    core_mode = 2;
    clear_logs();
    send_cmd(MSG_ADDR, 32'h7000_0000);
    repeat (40) @(negedge clk);
    check("nowd_busy",  32'(busy_o), 32'd1);
    check("nowd_err",   32'(err_o),  32'd0);
    check("nowd_ndone", 32'(n_done), 32'd0);
    check("nowd_nwr",   32'(wr_addr_q.size()), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    core_mode = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
